pool_layer_sequencer: RTL and testbench

- Parametrised successor to the per-channel max-pool integration stage, sitting between a conv layer's flattened feature-map bus and the next conv/FC stage.
- Pools a D-channel HxW map with a KxK window, stride K, producing one output element per clock.
- Adds a start/busy/done handshake, configurable window size, signed compare, and optional average mode.
- Output bus is registered and holds its value until overwritten.

---
 rtl/pool_layer_sequencer_if.sv | 43 ++++
 rtl/pool_layer_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pool_layer_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pool_layer_sequencer_if.sv
// Bus bundle for pool_layer_sequencer: start/mode request, flattened input
// map, registered pooled output map and the busy/done status.
// Both flattened buses are declared [0:...] so the element at bit offset o
// is bus[o +: DATA_WIDTH] with its MSB at the lower index.
interface pool_layer_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 6,
  parameter int unsigned H          = 28,
  parameter int unsigned W          = 28,
  parameter int unsigned K          = 2
);
  localparam int unsigned OH       = H / K;
  localparam int unsigned OW       = W / K;
  localparam int unsigned IN_BITS  = H * W * D * DATA_WIDTH;
  localparam int unsigned OUT_BITS = OH * OW * D * DATA_WIDTH;

  logic                start;
  logic                mode;
  logic [0:IN_BITS-1]  apInput;
  logic [0:OUT_BITS-1] apOutput;
  logic                busy;
  logic                done;

  // Upstream side: requests a pooling pass and observes the result.
  modport master (
    output start,
    output mode,
    output apInput,
    input  apOutput,
    input  busy,
    input  done
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  mode,
    input  apInput,
    output apOutput,
    output busy,
    output done
  );
endinterface

// File: rtl/pool_layer_sequencer.sv
// KxK / stride-K pooling sequencer over a D-channel HxW feature map.
// One output element is produced per clock while busy; done pulses once
// after the last element. Output map is registered and holds its contents.
// Optional feature macro: POOL_AVG_EN (mode=1 selects window average;
// without it mode is ignored and only the signed max path exists).
// K must be a power of two >= 2.
module pool_layer_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 6,
  parameter int unsigned H          = 28,
  parameter int unsigned W          = 28,
  parameter int unsigned K          = 2
) (
  input logic                   clk,
  input logic                   reset,
  pool_layer_sequencer_if.slave bus
);

  localparam int unsigned OH        = H / K;
  localparam int unsigned OW        = W / K;
  localparam int unsigned KK        = K * K;
  localparam int unsigned IN_BITS   = H * W * D * DATA_WIDTH;
  localparam int unsigned OUT_BITS  = OH * OW * D * DATA_WIDTH;
  localparam int unsigned IN_IDX_W  = $clog2(IN_BITS);
  localparam int unsigned OUT_IDX_W = $clog2(OUT_BITS);
  localparam int unsigned CW        = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned RW        = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned QW        = (OW > 1) ? $clog2(OW) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Output coordinate counters: c = channel, r = output row, q = output column.
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic [QW-1:0] q_q, q_d;

  logic wr_en;
  logic last_elem;

  logic [IN_IDX_W-1:0]         win_idx [KK];
  logic signed [DATA_WIDTH-1:0] win    [KK];
  logic signed [DATA_WIDTH-1:0] pool_max;
  logic signed [DATA_WIDTH-1:0] pooled;
  logic [OUT_IDX_W-1:0]        out_idx;

  assign last_elem = (c_q == CW'(D - 1)) && (r_q == RW'(OH - 1)) && (q_q == QW'(OW - 1));

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      c_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      q_q     <= q_d;
    end
  end

  // Next-state logic: walk (c,r,q) with q fastest, one element per RUN cycle.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    q_d     = q_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          c_d     = '0;
          r_d     = '0;
          q_d     = '0;
        end
      end
      StRun: begin
        wr_en = 1'b1;
        if (last_elem) begin
          state_d = StDone;
          c_d     = '0;
          r_d     = '0;
          q_d     = '0;
        end else if (q_q == QW'(OW - 1)) begin
          q_d = '0;
          if (r_q == RW'(OH - 1)) begin
            r_d = '0;
            c_d = c_q + CW'(1);
          end else begin
            r_d = r_q + RW'(1);
          end
        end else begin
          q_d = q_q + QW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);

  // Window mux: gather the KxK input elements addressed by the counters.
  // Trailing rows/columns beyond OH*K / OW*K are never addressed.
  always_comb begin
    for (int ky = 0; ky < int'(K); ky++) begin
      for (int kx = 0; kx < int'(K); kx++) begin
        win_idx[ky * int'(K) + kx] = IN_IDX_W'(
          ((32'(c_q) * H + 32'(r_q) * K + 32'(ky)) * W + 32'(q_q) * K + 32'(kx)) * DATA_WIDTH);
      end
    end
    for (int i = 0; i < int'(KK); i++) begin
      win[i] = bus.apInput[win_idx[i] +: DATA_WIDTH];
    end
  end

  // Signed maximum over the window; ties are irrelevant.
  always_comb begin
    pool_max = win[0];
    for (int i = 1; i < int'(KK); i++) begin
      if (win[i] > pool_max) begin
        pool_max = win[i];
      end
    end
  end

`ifdef POOL_AVG_EN
  localparam int unsigned LK    = $clog2(K);
  localparam int unsigned SUM_W = DATA_WIDTH + 2 * LK;

  // Mode is latched at the start edge so mid-run toggles have no effect.
  logic mode_q;
  logic signed [SUM_W-1:0]      win_sum;
  logic signed [DATA_WIDTH-1:0] pool_avg;

  // Latch the requested mode when a run is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if (state_q == StIdle && bus.start) begin
      mode_q <= bus.mode;
    end
  end

  // Window sum at full precision, then floor-divide by K*K via arithmetic shift.
  always_comb begin
    win_sum = '0;
    for (int i = 0; i < int'(KK); i++) begin
      win_sum = win_sum + SUM_W'(win[i]);
    end
    pool_avg = DATA_WIDTH'(win_sum >>> (2 * LK));
  end

  assign pooled = mode_q ? pool_avg : pool_max;
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign pooled      = pool_max;
`endif

  assign out_idx = OUT_IDX_W'(((32'(c_q) * OH + 32'(r_q)) * OW + 32'(q_q)) * DATA_WIDTH);

  // Output map register: one element rewritten per RUN cycle, others hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.apOutput <= '0;
    end else if (wr_en) begin
      bus.apOutput[out_idx +: DATA_WIDTH] <= pooled;
    end
  end

endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Directed bench for pool_layer_sequencer: two instances (4x4 and 5x5 maps,
// D=2, K=2), covering reset, timing, ignored restarts, held start, mid-run
// reset, non-divisible maps and the mode input.
module tb_pool_layer_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int win_tab [2][4][4];  // [channel][window r*2+q][element ky*2+kx]
  int exp_tab [2][4];     // [channel][window]

  pool_layer_sequencer_if #(.DATA_WIDTH(16), .D(2), .H(4), .W(4), .K(2)) bus_a ();
  pool_layer_sequencer_if #(.DATA_WIDTH(16), .D(2), .H(5), .W(5), .K(2)) bus_b ();

  pool_layer_sequencer #(.DATA_WIDTH(16), .D(2), .H(4), .W(4), .K(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  pool_layer_sequencer #(.DATA_WIDTH(16), .D(2), .H(5), .W(5), .K(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) bus_b.start = v;
    else     bus_a.start = v;
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? bus_b.busy : bus_a.busy;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? bus_b.done : bus_a.done;
  endfunction

  function automatic logic signed [15:0] get_out(input bit sel, input int c, input int r,
                                                 input int q);
    int off;
    off = ((c * 2 + r) * 2 + q) * 16;
    return sel ? bus_b.apOutput[off +: 16] : bus_a.apOutput[off +: 16];
  endfunction

  // Place win_tab into the top-left 4x4 of each channel.
  task automatic load(input bit sel);
    int y, x, hw, off;
    hw = sel ? 5 : 4;
    for (int c = 0; c < 2; c++) begin
      for (int w = 0; w < 4; w++) begin
        for (int e = 0; e < 4; e++) begin
          y   = (w / 2) * 2 + e / 2;
          x   = (w % 2) * 2 + e % 2;
          off = ((c * hw + y) * hw + x) * 16;
          if (sel) bus_b.apInput[off +: 16] = 16'(win_tab[c][w][e]);
          else     bus_a.apInput[off +: 16] = 16'(win_tab[c][w][e]);
        end
      end
    end
  endtask

  task automatic check_out(input bit sel, input string name);
    for (int c = 0; c < 2; c++) begin
      for (int w = 0; w < 4; w++) begin
        check($sformatf("%s_c%0d_w%0d", name, c, w), get_out(sel, c, w / 2, w % 2),
              exp_tab[c][w]);
      end
    end
  endtask

  // Raise start, take the start edge, then watch 20 edges (bounded).
  // Counts busy samples, first done edge (-1 if none) and done pulses.
  task automatic run(input bit sel, input int retrig_at, input bit hold, input int flip_at,
                     output int busy_n, output int done_e, output int done_n);
    busy_n = 0;
    done_e = -1;
    done_n = 0;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(sel, 1'b0);
    for (int e = 0; e < 20; e++) begin
      if (get_busy(sel) === 1'b1) busy_n++;
      if (get_done(sel) === 1'b1) begin
        done_n++;
        if (done_e < 0) done_e = e;
      end
      if (e == retrig_at)     set_start(sel, 1'b1);
      else if (!hold)         set_start(sel, 1'b0);
      if (hold && e == 19)    set_start(sel, 1'b0);
      if (e == flip_at)       bus_a.mode = ~bus_a.mode;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int busy_n, done_e, done_n;

    bus_a.start = 1'b0;
    bus_a.mode = 1'b0;
    bus_a.apInput = '0;
    bus_b.start = 1'b0;
    bus_b.mode = 1'b0;
    bus_b.apInput = '0;

    win_tab[0] = '{'{1, 5, -3, 2}, '{7, 7, 0, -1}, '{-8, -2, -6, -4}, '{0, 0, 0, 0}};
    win_tab[1] = '{'{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768},
                   '{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}};
    exp_tab[0] = '{5, 7, -2, 0};
    exp_tab[1] = '{-32768, -32768, -32768, -32768};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_zero", 32'(bus_a.apOutput === '0), 1);
    check("reset_busy", bus_a.busy, 0);
    check("reset_done", bus_a.done, 0);
    reset = 1'b0;
    load(1'b0);

    // Basic run: busy 8 cycles, done on edge 8, one pulse.
    run(1'b0, -1, 1'b0, -1, busy_n, done_e, done_n);
    check("r1_busy_cycles", busy_n, 8);
    check("r1_done_edge", done_e, 8);
    check("r1_done_pulses", done_n, 1);
    check_out(1'b0, "r1_max");

    // Start re-asserted during the run is ignored.
    run(1'b0, 3, 1'b0, -1, busy_n, done_e, done_n);
    check("retrig_busy_cycles", busy_n, 8);
    check("retrig_done_edge", done_e, 8);
    check("retrig_done_pulses", done_n, 1);

    // Start held high: RUN(8) DONE IDLE RUN(8) DONE within 20 edges.
    run(1'b0, -1, 1'b1, -1, busy_n, done_e, done_n);
    check("hold_busy_cycles", busy_n, 16);
    check("hold_done_edge", done_e, 8);
    check("hold_done_pulses", done_n, 2);

    // Reset during cycle 4 of a run aborts everything.
    set_start(1'b0, 1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", bus_a.busy, 0);
    check("midrst_done", bus_a.done, 0);
    check("midrst_out_zero", 32'(bus_a.apOutput === '0), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_done_after", bus_a.done, 0);
    check("midrst_busy_after", bus_a.busy, 0);

    // New channel-1 data, full run after the abort.
    win_tab[1] = '{'{3, -4, 2, 1}, '{-5, -6, -7, -9}, '{32767, 0, 0, 0}, '{-1, -1, -1, -1}};
    exp_tab[1] = '{3, -5, 32767, -1};
    load(1'b0);
    run(1'b0, -1, 1'b0, -1, busy_n, done_e, done_n);
    check("r5_done_edge", done_e, 8);
    check("r5_done_pulses", done_n, 1);
    check_out(1'b0, "r5_max");

    // 5x5 map: row 4 / column 4 are 0x7FFF and must never be read.
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 25; i++) begin
        bus_b.apInput[(c * 25 + i) * 16 +: 16] = 16'h7FFF;
      end
    end
    load(1'b1);
    run(1'b1, -1, 1'b0, -1, busy_n, done_e, done_n);
    check("b_busy_cycles", busy_n, 8);
    check("b_done_edge", done_e, 8);
    check_out(1'b1, "b_max");

    // mode=1 at the start edge, toggled mid-run.
    win_tab[0] = '{'{4, 5, 6, 7}, '{-1, -2, -2, -2}, '{-8, -2, -6, -4},
                   '{32767, 32767, 32767, 32767}};
    win_tab[1] = '{'{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768},
                   '{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}};
`ifdef POOL_AVG_EN
    exp_tab[0] = '{5, -2, -5, 32767};
`else
    exp_tab[0] = '{7, -1, -2, 32767};
`endif
    exp_tab[1] = '{-32768, -32768, -32768, -32768};
    load(1'b0);
    bus_a.mode = 1'b1;
    run(1'b0, -1, 1'b0, 2, busy_n, done_e, done_n);
    check("mode_done_edge", done_e, 8);
    check_out(1'b0, "mode");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
